// File: rtl/alu_sweep_bist.sv
// rtl/alu_sweep_bist.sv - sweep driver and CRC signature collector for the 8-bit ALU
//
// Applies one captured operand to the ALU across all 32 {op, const_sel}
// combinations. Each vector is held HOLD_CYCLES cycles and sampled in the
// last one. Every {status, result} sample is folded into a 16-bit CRC
// (poly 0x1021, 9 bits MSB first per sample).
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start, i_operand    sweep request (accepted in IDLE) and operand to capture
//   o_alu_input           captured operand driven to the ALU
//   o_alu_const_sel       ALU constant select (index[1:0] while sweeping)
//   o_alu_op              ALU operation select (index[4:2] while sweeping)
//   i_alu_result          ALU result
//   i_alu_status          ALU status flag
//   o_busy                sweep in progress
//   o_done                one-cycle pulse, signature final
//   o_signature           CRC accumulator
//   o_sample_valid        ALU is sampled at the closing edge of this cycle
//   o_sample_index        current vector index {op, const_sel}

module alu_sweep_bist #(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [15:0] SIG_SEED    = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_operand,
    output logic [7:0]  o_alu_input,
    output logic [1:0]  o_alu_const_sel,
    output logic [2:0]  o_alu_op,
    input  logic [7:0]  i_alu_result,
    input  logic        i_alu_status,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_signature,
    output logic        o_sample_valid,
    output logic [4:0]  o_sample_index
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_index;
    logic [3:0]  r_hold;
    logic [7:0]  r_operand;
    logic [15:0] r_sig;
    logic        w_accept;
    logic        w_sample;

    // Nine serial CRC steps unrolled into one cycle, status bit first.
    function automatic logic [15:0] crc_step9(input logic [15:0] sig, input logic [8:0] word);
        logic [15:0] s;
        logic        fb;
        s = sig;
        for (int i = 8; i >= 0; i--) begin
            fb = s[15] ^ word[i];
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_sample        = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        o_alu_op        = 3'd0;
        o_alu_const_sel = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                o_busy          = 1'b1;
                o_alu_op        = r_index[4:2];
                o_alu_const_sel = r_index[1:0];
                w_sample        = (r_hold == HOLD_LAST);
                if (w_sample && (r_index == 5'd31)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Index wraps 31 -> 0 on the last sample, so it rests at 0 outside a sweep.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_operand <= 8'd0;
            r_sig     <= SIG_SEED;
            r_index   <= 5'd0;
            r_hold    <= 4'd0;
        end else if (w_accept) begin
            r_operand <= i_operand;
            r_sig     <= SIG_SEED;
            r_index   <= 5'd0;
            r_hold    <= 4'd0;
        end else if (r_state == ST_SWEEP) begin
            if (w_sample) begin
                r_sig   <= crc_step9(r_sig, {i_alu_status, i_alu_result});
                r_index <= r_index + 5'd1;
                r_hold  <= 4'd0;
            end else begin
                r_hold  <= r_hold + 4'd1;
            end
        end
    end

    assign o_alu_input    = r_operand;
    assign o_signature    = r_sig;
    assign o_sample_valid = w_sample;
    assign o_sample_index = r_index;

endmodule

// File: tb/tb_alu_sweep_bist.sv
// tb/tb_alu_sweep_bist.sv - self-checking bench for alu_sweep_bist

module tb_alu_sweep_bist;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start   [NI];
    logic [7:0]  operand [NI];
    logic [7:0]  alu_in  [NI];
    logic [1:0]  cs      [NI];
    logic [2:0]  aop     [NI];
    logic [7:0]  res     [NI];
    logic        st      [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic [15:0] sig     [NI];
    logic        sv      [NI];
    logic [4:0]  sidx    [NI];
    int          mode    [NI];

    int n_checks = 0;
    int n_pass   = 0;

    // instance 0: hold 2, seed FFFF; instance 1: hold 2, seed 0; instance 2: hold 1, seed FFFF
    function automatic int hold_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic logic [15:0] seed_of(input int k);
        return (k == 1) ? 16'h0000 : 16'hFFFF;
    endfunction

    // mode 0: reference ALU, 1: echo index, 2: 9'h001 at index 31 only, 3: all zero
    function automatic logic [8:0] alu_fn(input int m, input logic [7:0] a,
                                          input logic [1:0] c_sel, input logic [2:0] o);
        logic [7:0] c;
        logic [8:0] r;
        case (c_sel)
            2'd0:    c = 8'h0F;
            2'd1:    c = 8'h55;
            2'd2:    c = 8'hA5;
            default: c = 8'hFF;
        endcase
        case (m)
            1: r = {4'b0000, o, c_sel};
            2: r = ({o, c_sel} == 5'd31) ? 9'h001 : 9'h000;
            3: r = 9'h000;
            default: begin
                case (o)
                    3'd0:    r = {1'b0, a} + {1'b0, c};
                    3'd1:    r = {1'b0, a} - {1'b0, c};
                    3'd2:    r = {((a & c) == 8'd0), a & c};
                    3'd3:    r = {((a | c) == 8'd0), a | c};
                    3'd4:    r = {((a ^ c) == 8'd0), a ^ c};
                    3'd5:    r = {1'b0, a << c_sel};
                    3'd6:    r = {(a < c), a};
                    default: r = {1'b0, ~a};
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic logic [15:0] crc9(input logic [15:0] s_in, input logic [8:0] w);
        logic [15:0] s;
        logic        fb;
        s = s_in;
        for (int b = 8; b >= 0; b--) begin
            fb = s[15] ^ w[b];
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    assign {st[0], res[0]} = alu_fn(mode[0], alu_in[0], cs[0], aop[0]);
    assign {st[1], res[1]} = alu_fn(mode[1], alu_in[1], cs[1], aop[1]);
    assign {st[2], res[2]} = alu_fn(mode[2], alu_in[2], cs[2], aop[2]);

    alu_sweep_bist #(.HOLD_CYCLES(2), .SIG_SEED(16'hFFFF)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start[0]), .i_operand(operand[0]),
        .o_alu_input(alu_in[0]), .o_alu_const_sel(cs[0]), .o_alu_op(aop[0]),
        .i_alu_result(res[0]), .i_alu_status(st[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_signature(sig[0]), .o_sample_valid(sv[0]), .o_sample_index(sidx[0])
    );

    alu_sweep_bist #(.HOLD_CYCLES(2), .SIG_SEED(16'h0000)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start[1]), .i_operand(operand[1]),
        .o_alu_input(alu_in[1]), .o_alu_const_sel(cs[1]), .o_alu_op(aop[1]),
        .i_alu_result(res[1]), .i_alu_status(st[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_signature(sig[1]), .o_sample_valid(sv[1]), .o_sample_index(sidx[1])
    );

    alu_sweep_bist #(.HOLD_CYCLES(1), .SIG_SEED(16'hFFFF)) u_dut_c (
        .i_clk(clk), .i_reset(rst), .i_start(start[2]), .i_operand(operand[2]),
        .o_alu_input(alu_in[2]), .o_alu_const_sel(cs[2]), .o_alu_op(aop[2]),
        .i_alu_result(res[2]), .i_alu_status(st[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_signature(sig[2]), .o_sample_valid(sv[2]), .o_sample_index(sidx[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: m_t < 0 idle, 0..32*h-1 position within the sweep, 32*h the done cycle.
    int          m_t   [NI] = '{-1, -1, -1};
    logic [15:0] m_sig [NI] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    logic [7:0]  m_op  [NI] = '{8'd0, 8'd0, 8'd0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            int         h;
            logic [4:0] idx;
            h = hold_of(k);
            if (rst) begin
                m_t[k]   = -1;
                m_sig[k] = seed_of(k);
                m_op[k]  = 8'd0;
            end else if (m_t[k] < 0) begin
                if (start[k]) begin
                    m_t[k]   = 0;
                    m_sig[k] = seed_of(k);
                    m_op[k]  = operand[k];
                end
            end else if (m_t[k] < 32 * h) begin
                if (m_t[k] % h == h - 1) begin
                    idx      = 5'(m_t[k] / h);
                    m_sig[k] = crc9(m_sig[k], alu_fn(mode[k], m_op[k], idx[1:0], idx[4:2]));
                end
                m_t[k] = m_t[k] + 1;
            end else begin
                m_t[k] = -1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int         h;
            bit         swp;
            logic [4:0] idx;
            h   = hold_of(k);
            swp = (m_t[k] >= 0) && (m_t[k] < 32 * h);
            idx = swp ? 5'(m_t[k] / h) : 5'd0;
            chk($sformatf("cyc_busy%0d", k), busy[k], swp);
            chk($sformatf("cyc_done%0d", k), done[k], m_t[k] == 32 * h);
            chk($sformatf("cyc_sample_valid%0d", k), sv[k], swp && (m_t[k] % h == h - 1));
            chk($sformatf("cyc_signature%0d", k), sig[k], m_sig[k]);
            chk($sformatf("cyc_alu_input%0d", k), alu_in[k], m_op[k]);
            chk($sformatf("cyc_alu_op%0d", k), aop[k], idx[4:2]);
            chk($sformatf("cyc_const_sel%0d", k), cs[k], idx[1:0]);
            if (swp) chk($sformatf("cyc_sample_index%0d", k), sidx[k], idx);
        end
    end

    task automatic do_start(input int k, input logic [7:0] v);
        @(posedge clk);
        #1;
        start[k]   = 1'b1;
        operand[k] = v;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    // Runs until done (bounded); optionally pokes start mid-sweep and/or in the done cycle.
    task automatic measure(input int k, input int exp_busy, input string tag,
                           input int poke_mid, input bit poke_done,
                           output logic [15:0] sig_done, output int max_run);
        int nb = 0;
        int nsv = 0;
        int run = 0;
        bit got = 0;
        bit poked = 0;
        max_run  = 0;
        sig_done = 16'hxxxx;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (poked) begin
                start[k] = 1'b0;
                poked    = 1'b0;
            end
            if (done[k]) begin
                got      = 1'b1;
                sig_done = sig[k];
                if (poke_done) begin
                    start[k]   = 1'b1;
                    operand[k] = 8'hC3;
                    poked      = 1'b1;
                end
                break;
            end
            if (busy[k]) nb++;
            if (sv[k]) begin
                nsv++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (c == poke_mid) begin
                start[k]   = 1'b1;
                operand[k] = 8'hC3;
                poked      = 1'b1;
            end
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        chk({tag, "_busy_cycles"}, nb, exp_busy);
        chk({tag, "_samples"}, nsv, 32);
        @(negedge clk);
        if (poked) start[k] = 1'b0;
        chk({tag, "_done_one_cycle"}, done[k], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        int          mr;
        bit          saw;
        logic [7:0]  vals [3] = '{8'd0, 8'd150, 8'd250};
        for (int k = 0; k < NI; k++) begin
            start[k]   = 1'b0;
            operand[k] = 8'd0;
            mode[k]    = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_sample_valid", sv[0], 1'b0);
        chk("rst_sample_index", sidx[0], 5'd0);
        chk("rst_alu_input", alu_in[0], 8'd0);
        chk("rst_alu_op", aop[0], 3'd0);
        chk("rst_const_sel", cs[0], 2'd0);
        chk("rst_signature_a", sig[0], 16'hFFFF);
        chk("rst_signature_b", sig[1], 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequencing with echo stub, operand 250
        mode[0] = 1;
        do_start(0, 8'd250);
        measure(0, 64, "seq", -1, 1'b0, s, mr);
        chk("seq_alu_input", alu_in[0], 8'd250);
        chk("seq_max_consecutive_samples", mr, 1);

        // Signature arithmetic with seed 0
        mode[1] = 2;
        do_start(1, 8'h33);
        measure(1, 64, "spike", -1, 1'b0, s, mr);
        chk("spike_signature", s, 16'h1021);
        mode[1] = 3;
        do_start(1, 8'h44);
        measure(1, 64, "zero", -1, 1'b0, s, mr);
        chk("zero_signature", s, 16'h0000);

        // Reference ALU, default seed
        mode[0] = 0;
        for (int i = 0; i < 3; i++) begin
            do_start(0, vals[i]);
            measure(0, 64, $sformatf("real%0d", vals[i]), -1, 1'b0, s, mr);
        end

        // Hold of one cycle: 32 back-to-back samples
        mode[2] = 0;
        do_start(2, 8'd150);
        measure(2, 32, "hold1", -1, 1'b0, s, mr);
        chk("hold1_consecutive", mr, 32);

        // start pulsed during SWEEP and during DONE is ignored
        do_start(0, 8'h5A);
        measure(0, 64, "ignore", 20, 1'b1, s, mr);
        saw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy[0]) saw = 1'b1;
        end
        chk("ignore_no_restart", saw, 1'b0);
        chk("ignore_alu_input", alu_in[0], 8'h5A);

        // start held high: exactly one idle cycle between sweeps
        @(posedge clk);
        #1;
        start[0]   = 1'b1;
        operand[0] = 8'd77;
        measure(0, 64, "held1", -1, 1'b0, s, mr);
        chk("held_idle_gap", busy[0], 1'b0);
        @(negedge clk);
        chk("held_restart", busy[0], 1'b1);
        start[0] = 1'b0;
        measure(0, 63, "held2", -1, 1'b0, s, mr);

        // Asynchronous reset mid-sweep
        do_start(0, 8'd99);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", busy[0], 1'b0);
        chk("arst_done", done[0], 1'b0);
        chk("arst_sample_valid", sv[0], 1'b0);
        chk("arst_sample_index", sidx[0], 5'd0);
        chk("arst_alu_input", alu_in[0], 8'd0);
        chk("arst_alu_op", aop[0], 3'd0);
        chk("arst_const_sel", cs[0], 2'd0);
        chk("arst_signature", sig[0], 16'hFFFF);
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done[0] || busy[0]) saw = 1'b1;
        end
        chk("arst_no_resume", saw, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
